alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
- Producer side of the ALU operand interface: turns decoded RV32I integer ops (OP, OP-IMM, LUI, AUIPC) into a registered alu_inputs_t plus tag for the ALU.
- Sits between decode/register-read and the ALU.
- Valid/ready on both sides; a 2-entry skid buffer gives a fully registered in_ready and full throughput.

Parameters:
- ID_W, 3, width of the instruction tag passed through alongside the ALU inputs.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  drop all buffered ops this cycle
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- in_req  in  alu_issue_req_t  fn3[2:0], fn7_5, is_imm, op1_sel, rs1[31:0], rs2[31:0], imm[31:0], pc[31:0], id[ID_W-1:0]
- out_valid  out  1  ALU inputs valid
- out_ready  in  1  ALU accepts
- out_alu  out  alu_inputs_t  encoded ALU inputs
- out_id  out  ID_W  tag of out_alu

Behaviour:
- Reset: out_valid=0, in_ready=1, skid empty, out_alu=0, out_id=0.
- Encode (combinational, applied on accept):
  - op1 = rs1 / pc / 0 per op1_sel (RS1/PC/ZERO). op2 = is_imm ? imm : rs2.
  - sgn = (fn3 != 3'b011): SLTU zero-pads, every other op sign-pads.
  - in1 = {sgn & op1[31], op1}; in2 = {sgn & op2[31], op2}.
  - shifter_in = op1; shift_amount = op2[4:0].
  - fn3 000: subtract = fn7_5 & !is_imm; logic_op = ADD.
  - fn3 010/011: subtract = 1; slt_path = 1; logic_op = ADD.
  - fn3 100/110/111: logic_op = XOR/OR/AND.
  - fn3 001: shifter_path = 1; lshift = 1.
  - fn3 101: shifter_path = 1; arith = fn7_5. For OP-IMM, fn7_5 is supplied by decode from imm[10].
  - All unlisted fields are 0. op1_sel != RS1 forces the fn3 = 000 ADD encoding.
- States: EMPTY (out reg invalid), ONE (out reg valid), TWO (out reg and skid valid).
  - EMPTY: accept -> ONE, data loaded into out reg.
  - ONE: accept without out_ready -> TWO, data into skid. Accept with out_ready -> ONE, out reg reloaded. out_ready without accept -> EMPTY.
  - TWO: out_ready -> ONE, skid moves to out reg. Otherwise hold.
- in_ready = (state != TWO), driven from a register. There is no combinational in_valid->in_ready or out_ready->in_ready path.
- Latency: 1 cycle accept -> out_valid. Sustained 1 op/cycle when out_ready=1.
- Ordering is strict FIFO. Payload is stable while out_valid & !out_ready.
- flush: next state EMPTY; any accept in that cycle is discarded. rst has priority over flush.
- Reset mid-operation: buffered ops are lost and no stale out_valid appears.

Optional Feature:
- Macro ALU_ISSUE_PERF_EN.
- With macro: 32-bit output ports perf_issued (out handshakes) and perf_stall (cycles with out_valid & !out_ready).
  - Both saturate at 2^32-1 and are cleared by rst, not by flush.
- Without macro: ports and counters are absent.

Decomposition:
- cpu_types gains alu_op1_sel_t enum (RS1, PC, ZERO) and alu_issue_req_t packed struct (ID field sized to 3).
- Fields use XLEN from riscv_types.
- Sub-module alu_input_encode: pure combinational alu_issue_req_t -> alu_inputs_t, instantiated once at the input.

Test Plan:
- ADD reg: rs1=0x7FFFFFFF, rs2=1, fn3=000 -> next cycle out_valid=1; in1=0x07FFFFFFF, in2=0x000000001, subtract=0, logic_op=ADD.
- SLTU vs SLT, rs1=0xFFFFFFFF:
  - SLTU -> in1 bit32=0.
  - SLT -> in1=0x1FFFFFFFF, slt_path=1, subtract=1.
- SRAI, imm=0x40000405 (fn7_5=1) -> shifter_path=1, arith=1, shift_amount=5. SUB with is_imm=1 -> subtract=0.
- Backpressure: 3 back-to-back ops A,B,C, out_ready=0:
  - A and B accepted, then in_ready=0, C held.
  - Raise out_ready -> A, B, C emerge in order, one per cycle.
- Flush in TWO with in_valid=1 -> next cycle out_valid=0, in_ready=1, no op emitted.
- With ALU_ISSUE_PERF_EN: 4 ops, 2 stall cycles -> perf_issued=4, perf_stall=2; after rst both 0.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared types for the ALU issue stage: operand select, issue request,
// encoded ALU inputs and the skid-buffer state encoding.
// Imported by alu_input_encode and alu_issue.
package alu_issue_pkg;

  localparam int XLEN     = 32;
  localparam int ALU_ID_W = 3;

  typedef enum logic [1:0] {
    OP1_RS1  = 2'd0,
    OP1_PC   = 2'd1,
    OP1_ZERO = 2'd2
  } alu_op1_sel_t;

  typedef enum logic [1:0] {
    LOGIC_ADD = 2'd0,
    LOGIC_XOR = 2'd1,
    LOGIC_OR  = 2'd2,
    LOGIC_AND = 2'd3
  } alu_logic_op_t;

  typedef struct packed {
    logic [2:0]          fn3;
    logic                fn7_5;
    logic                is_imm;
    alu_op1_sel_t        op1_sel;
    logic [XLEN-1:0]     rs1;
    logic [XLEN-1:0]     rs2;
    logic [XLEN-1:0]     imm;
    logic [XLEN-1:0]     pc;
    logic [ALU_ID_W-1:0] id;
  } alu_issue_req_t;

  typedef struct packed {
    logic [XLEN:0]   in1;          // sign/zero-extended operand 1
    logic [XLEN:0]   in2;          // sign/zero-extended operand 2
    logic [XLEN-1:0] shifter_in;
    logic [4:0]      shift_amount;
    logic            subtract;
    logic            slt_path;
    alu_logic_op_t   logic_op;
    logic            shifter_path;
    logic            lshift;
    logic            arith;
  } alu_inputs_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } issue_state_t;

endpackage

// File: rtl/alu_input_encode.sv
// Purpose: combinational encode of a decoded RV32I integer op into ALU inputs.
// Ports: req (alu_issue_req_t) in, alu (alu_inputs_t) out.
// Latency: zero (pure combinational); no flow control of its own.
module alu_input_encode
  import alu_issue_pkg::*;
(
  input  alu_issue_req_t req,
  output alu_inputs_t    alu
);

  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [2:0]      fn3;
  logic            is_rs1;
  logic            sgn;

  always_comb begin
    alu    = '0;
    is_rs1 = (req.op1_sel == OP1_RS1);
    // LUI/AUIPC are plain adds regardless of whatever fn3 bits decode left.
    fn3    = is_rs1 ? req.fn3 : 3'b000;

    case (req.op1_sel)
      OP1_RS1: op1 = req.rs1;
      OP1_PC:  op1 = req.pc;
      default: op1 = '0;
    endcase
    op2 = req.is_imm ? req.imm : req.rs2;

    // Only SLTU compares unsigned; everything else extends with the sign bit.
    sgn = (fn3 != 3'b011);

    alu.in1          = {sgn & op1[XLEN-1], op1};
    alu.in2          = {sgn & op2[XLEN-1], op2};
    alu.shifter_in   = op1;
    alu.shift_amount = op2[4:0];

    case (fn3)
      3'b000: begin
        // There is no SUBI: fn7_5 only selects subtract for register ops.
        alu.subtract = req.fn7_5 & ~req.is_imm & is_rs1;
        alu.logic_op = LOGIC_ADD;
      end
      3'b010, 3'b011: begin
        alu.subtract = 1'b1;
        alu.slt_path = 1'b1;
        alu.logic_op = LOGIC_ADD;
      end
      3'b100: alu.logic_op = LOGIC_XOR;
      3'b110: alu.logic_op = LOGIC_OR;
      3'b111: alu.logic_op = LOGIC_AND;
      3'b001: begin
        alu.shifter_path = 1'b1;
        alu.lshift       = 1'b1;
      end
      default: begin // 3'b101: SRL/SRA, fn7_5 already carries imm[10] for OP-IMM
        alu.shifter_path = 1'b1;
        alu.arith        = req.fn7_5;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// Purpose: registered ALU operand issue stage with a 2-entry skid buffer.
// Latency: 1 cycle accept -> out_valid; 1 op/cycle sustained with out_ready=1.
// Backpressure: in_ready is a flop, low only when out reg and skid are both full.
// Ports: clk, rst (sync, active-high), flush, in_valid/in_ready/in_req,
//        out_valid/out_ready/out_alu/out_id.
// Optional: define ALU_ISSUE_PERF_EN to add perf_issued / perf_stall counters.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int ID_W = ALU_ID_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  alu_issue_req_t in_req,
  output logic           out_valid,
  input  logic           out_ready,
  output alu_inputs_t    out_alu,
  output logic [ID_W-1:0] out_id
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]    perf_issued,
  output logic [31:0]    perf_stall
`endif
);

  alu_inputs_t     enc_alu;
  logic [ID_W-1:0] enc_id;

  alu_input_encode u_encode (
    .req (in_req),
    .alu (enc_alu)
  );

  assign enc_id = ID_W'(in_req.id);

  issue_state_t    state_q, state_nxt;
  logic            in_ready_q;
  alu_inputs_t     out_alu_q, skid_alu_q;
  logic [ID_W-1:0] out_id_q, skid_id_q;

  logic accept;
  logic load_out;
  logic load_skid;
  logic skid_to_out;

  assign accept    = in_valid & in_ready_q;
  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_alu   = out_alu_q;
  assign out_id    = out_id_q;

  always_comb begin
    state_nxt   = state_q;
    load_out    = 1'b0;
    load_skid   = 1'b0;
    skid_to_out = 1'b0;

    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_nxt = ST_ONE;
          load_out  = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && !out_ready) begin
          state_nxt = ST_TWO;
          load_skid = 1'b1;
        end else if (accept) begin
          load_out = 1'b1;
        end else if (out_ready) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (out_ready) begin
          state_nxt   = ST_ONE;
          skid_to_out = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase

    // Flush discards everything, including an op handshaken this cycle.
    if (flush) begin
      state_nxt   = ST_EMPTY;
      load_out    = 1'b0;
      load_skid   = 1'b0;
      skid_to_out = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      out_alu_q  <= '0;
      out_id_q   <= '0;
      skid_alu_q <= '0;
      skid_id_q  <= '0;
    end else begin
      state_q    <= state_nxt;
      // Registered copy of (next state != TWO) keeps in_ready off any comb path.
      in_ready_q <= (state_nxt != ST_TWO);
      if (load_out) begin
        out_alu_q <= enc_alu;
        out_id_q  <= enc_id;
      end else if (skid_to_out) begin
        out_alu_q <= skid_alu_q;
        out_id_q  <= skid_id_q;
      end
      if (load_skid) begin
        skid_alu_q <= enc_alu;
        skid_id_q  <= enc_id;
      end
    end
  end

`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] perf_issued_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issued_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (out_valid && out_ready && (perf_issued_q != 32'hFFFF_FFFF))
        perf_issued_q <= perf_issued_q + 32'd1;
      if (out_valid && !out_ready && (perf_stall_q != 32'hFFFF_FFFF))
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_issued = perf_issued_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: encode vectors, backpressure ordering,
// flush, mid-operation reset and (when enabled) the perf counters.
module tb_alu_issue;
  import alu_issue_pkg::*;

  logic           clk = 1'b0;
  logic           rst;
  logic           flush;
  logic           in_valid;
  logic           in_ready;
  alu_issue_req_t in_req;
  logic           out_valid;
  logic           out_ready;
  alu_inputs_t    out_alu;
  logic [2:0]     out_id;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0]    perf_issued;
  logic [31:0]    perf_stall;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue #(.ID_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_req    (in_req),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_alu   (out_alu),
    .out_id    (out_id)
`ifdef ALU_ISSUE_PERF_EN
    ,
    .perf_issued (perf_issued),
    .perf_stall  (perf_stall)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic alu_issue_req_t mk(input logic [2:0] fn3, input logic fn7_5,
                                        input logic is_imm, input alu_op1_sel_t sel,
                                        input logic [31:0] rs1, input logic [31:0] rs2,
                                        input logic [31:0] imm, input logic [31:0] pc,
                                        input logic [2:0] id);
    alu_issue_req_t r;
    r.fn3 = fn3; r.fn7_5 = fn7_5; r.is_imm = is_imm; r.op1_sel = sel;
    r.rs1 = rs1; r.rs2 = rs2; r.imm = imm; r.pc = pc; r.id = id;
    return r;
  endfunction

  // Present one op with out_ready=1; returns one negedge later when it sits in the out reg.
  task automatic issue_one(input alu_issue_req_t r);
    in_valid  = 1'b1;
    in_req    = r;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_req = '0;
    @(negedge clk);
    do_reset();

    // Reset state
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_alu",   64'(out_alu.in1), 64'd0);
    check("rst_out_id",    64'(out_id),    64'd0);

    // ADD reg
    issue_one(mk(3'b000, 1'b0, 1'b0, OP1_RS1, 32'h7FFF_FFFF, 32'h1, 32'h0, 32'h0, 3'd5));
    check("add_valid", 64'(out_valid), 64'd1);
    check("add_in1",   64'(out_alu.in1), 64'h0_7FFF_FFFF);
    check("add_in2",   64'(out_alu.in2), 64'h0_0000_0001);
    check("add_sub",   64'(out_alu.subtract), 64'd0);
    check("add_logic", 64'(out_alu.logic_op), 64'(LOGIC_ADD));
    check("add_id",    64'(out_id), 64'd5);
    @(negedge clk);
    check("add_drained", 64'(out_valid), 64'd0);

    // SLTU vs SLT
    issue_one(mk(3'b011, 1'b0, 1'b0, OP1_RS1, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 3'd1));
    check("sltu_in1", 64'(out_alu.in1), 64'h0_FFFF_FFFF);
    check("sltu_slt", 64'(out_alu.slt_path), 64'd1);
    issue_one(mk(3'b010, 1'b0, 1'b0, OP1_RS1, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 3'd2));
    check("slt_in1", 64'(out_alu.in1), 64'h1_FFFF_FFFF);
    check("slt_slt", 64'(out_alu.slt_path), 64'd1);
    check("slt_sub", 64'(out_alu.subtract), 64'd1);

    // SRAI
    issue_one(mk(3'b101, 1'b1, 1'b1, OP1_RS1, 32'h8000_0000, 32'h0, 32'h4000_0405, 32'h0, 3'd3));
    check("srai_shift", 64'(out_alu.shifter_path), 64'd1);
    check("srai_arith", 64'(out_alu.arith), 64'd1);
    check("srai_amt",   64'(out_alu.shift_amount), 64'd5);
    check("srai_lsh",   64'(out_alu.lshift), 64'd0);
    check("srai_sin",   64'(out_alu.shifter_in), 64'h8000_0000);

    // fn7_5 with is_imm must not subtract; register SUB must
    issue_one(mk(3'b000, 1'b1, 1'b1, OP1_RS1, 32'h10, 32'h0, 32'h3, 32'h0, 3'd4));
    check("subimm_sub", 64'(out_alu.subtract), 64'd0);
    check("subimm_in2", 64'(out_alu.in2), 64'h0_0000_0003);
    issue_one(mk(3'b000, 1'b1, 1'b0, OP1_RS1, 32'h10, 32'h8000_0000, 32'h3, 32'h0, 3'd4));
    check("sub_sub", 64'(out_alu.subtract), 64'd1);
    check("sub_in2", 64'(out_alu.in2), 64'h1_8000_0000);

    // SLL, logic ops
    issue_one(mk(3'b001, 1'b0, 1'b0, OP1_RS1, 32'h1, 32'h23, 32'h0, 32'h0, 3'd0));
    check("sll_lsh", 64'(out_alu.lshift), 64'd1);
    check("sll_amt", 64'(out_alu.shift_amount), 64'd3);
    issue_one(mk(3'b100, 1'b0, 1'b0, OP1_RS1, 32'h1, 32'h2, 32'h0, 32'h0, 3'd0));
    check("xor_op", 64'(out_alu.logic_op), 64'(LOGIC_XOR));
    issue_one(mk(3'b110, 1'b0, 1'b0, OP1_RS1, 32'h1, 32'h2, 32'h0, 32'h0, 3'd0));
    check("or_op", 64'(out_alu.logic_op), 64'(LOGIC_OR));
    issue_one(mk(3'b111, 1'b0, 1'b0, OP1_RS1, 32'h1, 32'h2, 32'h0, 32'h0, 3'd0));
    check("and_op", 64'(out_alu.logic_op), 64'(LOGIC_AND));

    // LUI / AUIPC: op1 forced, ADD encoding regardless of fn3
    issue_one(mk(3'b000, 1'b0, 1'b1, OP1_ZERO, 32'hDEAD_BEEF, 32'h0, 32'h1234_5000, 32'h0, 3'd6));
    check("lui_in1", 64'(out_alu.in1), 64'd0);
    check("lui_in2", 64'(out_alu.in2), 64'h0_1234_5000);
    issue_one(mk(3'b111, 1'b1, 1'b1, OP1_PC, 32'h0, 32'h0, 32'h0000_1000, 32'h8000_0000, 3'd7));
    check("auipc_in1",   64'(out_alu.in1), 64'h1_8000_0000);
    check("auipc_logic", 64'(out_alu.logic_op), 64'(LOGIC_ADD));
    check("auipc_sub",   64'(out_alu.subtract), 64'd0);
    @(negedge clk);

    // Backpressure: A, B accepted, C held, then drained in order
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_req    = mk(3'b000, 1'b0, 1'b0, OP1_RS1, 32'hA, 32'h0, 32'h0, 32'h0, 3'd1);
    @(negedge clk);
    check("bp_a_valid", 64'(out_valid), 64'd1);
    check("bp_a_rdy",   64'(in_ready), 64'd1);
    in_req = mk(3'b000, 1'b0, 1'b0, OP1_RS1, 32'hB, 32'h0, 32'h0, 32'h0, 3'd2);
    @(negedge clk);
    check("bp_full_rdy", 64'(in_ready), 64'd0);
    in_req = mk(3'b000, 1'b0, 1'b0, OP1_RS1, 32'hC, 32'h0, 32'h0, 32'h0, 3'd3);
    @(negedge clk);
    check("bp_hold_rdy", 64'(in_ready), 64'd0);
    check("bp_hold_id",  64'(out_id), 64'd1);
    check("bp_hold_in1", 64'(out_alu.in1), 64'hA);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_out_b", 64'(out_id), 64'd2);
    check("bp_b_rdy", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_out_c",   64'(out_id), 64'd3);
    check("bp_c_in1",   64'(out_alu.in1), 64'hC);
    check("bp_c_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    check("bp_empty", 64'(out_valid), 64'd0);

    // Flush while full with a new op offered
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_req    = mk(3'b000, 1'b0, 1'b0, OP1_RS1, 32'h1, 32'h0, 32'h0, 32'h0, 3'd1);
    @(negedge clk);
    in_req    = mk(3'b000, 1'b0, 1'b0, OP1_RS1, 32'h2, 32'h0, 32'h0, 32'h0, 3'd2);
    @(negedge clk);
    check("fl_full", 64'(in_ready), 64'd0);
    flush  = 1'b1;
    in_req = mk(3'b000, 1'b0, 1'b0, OP1_RS1, 32'h4, 32'h0, 32'h0, 32'h0, 3'd4);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_rdy",   64'(in_ready), 64'd1);
    @(negedge clk);
    check("fl_still_empty", 64'(out_valid), 64'd0);

    // Flush in ONE with an accept in the same cycle: the accept is dropped
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl1_valid", 64'(out_valid), 64'd0);

    // Reset mid-operation with an op offered
    out_ready = 1'b0;
    in_valid  = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    check("mrst_valid", 64'(out_valid), 64'd0);
    check("mrst_rdy",   64'(in_ready), 64'd1);
    @(negedge clk);
    check("mrst_no_stale", 64'(out_valid), 64'd0);

`ifdef ALU_ISSUE_PERF_EN
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_req    = mk(3'b000, 1'b0, 1'b0, OP1_RS1, 32'h1, 32'h0, 32'h0, 32'h0, 3'd1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    issue_one(in_req);
    issue_one(in_req);
    issue_one(in_req);
    @(negedge clk);
    check("perf_issued", 64'(perf_issued), 64'd4);
    check("perf_stall",  64'(perf_stall),  64'd2);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("perf_flush_keep", 64'(perf_issued), 64'd4);
    do_reset();
    check("perf_rst_issued", 64'(perf_issued), 64'd0);
    check("perf_rst_stall",  64'(perf_stall),  64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
